// File: rtl/pc_stack.sv
// pc_stack
// Program-counter stage feeding the program ROM. It produces the instruction
// address and supports sequential increment, absolute jumps, subroutine
// call/return through a small internal return-address stack, and stall.
//
// Parameters:
//   ADDR_W   - width of the PC and of every return address
//   DEPTH    - number of return-stack entries (power of two, at least 2)
//   RESET_PC - PC value loaded by reset
//
// Ports:
//   clk     - single clock, all state changes on the rising edge
//   reset   - synchronous active-high reset, overrides every other input
//   stall   - freeze PC, stack pointer, stack contents and flags
//   jump    - load target into PC
//   call    - push pc+1, then load target into PC
//   ret     - pop the top of stack into PC
//   target  - destination for jump/call
//   pc      - registered current PC (program-memory address)
//   sp      - number of valid stack entries, 0..DEPTH
//   empty   - sp == 0
//   full    - sp == DEPTH
//   ovf     - sticky, set by a call while full
//   unf     - sticky, set by a ret while empty
//
// Request priority on each edge: reset > stall > ret > call > jump > increment.
module pc_stack #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       jump,
  input  logic                       call,
  input  logic                       ret,
  input  logic [ADDR_W-1:0]          target,
  output logic [ADDR_W-1:0]          pc,
  output logic [$clog2(DEPTH):0]     sp,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SP_W  = PTR_W + 1;

  // Return-address storage. Not reset: sp=0 makes stale entries unreachable.
  logic [ADDR_W-1:0] stack_mem [DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [SP_W-1:0]   sp_dec;
  logic [PTR_W-1:0]  push_idx;
  logic [PTR_W-1:0]  pop_idx;
  logic [ADDR_W-1:0] top_addr;

  // Request decode after priority resolution. A ret always masks a call or
  // jump in the same cycle, and a call always masks a jump.
  logic do_ret;
  logic do_call;
  logic do_jump;
  logic do_push;
  logic do_pop;

  // Status flags follow the registered stack pointer directly.
  assign empty = (sp == '0);
  assign full  = (sp == SP_W'(DEPTH));

  // Next sequential address; wraps naturally at 2^ADDR_W.
  assign pc_inc = pc + ADDR_W'(1);

  // Stack indexing. The push slot is sp itself (only used when not full, so
  // the top bit is zero); the pop slot is sp-1 (only used when not empty).
  assign sp_dec   = sp - SP_W'(1);
  assign push_idx = sp[PTR_W-1:0];
  assign pop_idx  = sp_dec[PTR_W-1:0];
  assign top_addr = stack_mem[pop_idx];

  assign do_ret  = !stall && ret;
  assign do_call = !stall && !ret && call;
  assign do_jump = !stall && !ret && !call && jump;
  assign do_push = do_call && !full;
  assign do_pop  = do_ret && !empty;

  // Return-stack write port. A call while full discards the push so the
  // existing entries stay intact; reset does not touch the storage.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  // PC, stack pointer and sticky error flags. A ret on an empty stack
  // behaves like a plain increment but records the underflow. A call while
  // full still redirects the PC, only the return address is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= ADDR_W'(RESET_PC);
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (!stall) begin
      if (do_ret) begin
        if (do_pop) begin
          pc <= top_addr;
          sp <= sp_dec;
        end else begin
          pc  <= pc_inc;
          unf <= 1'b1;
        end
      end else if (do_call) begin
        pc <= target;
        if (do_push) begin
          sp <= sp + SP_W'(1);
        end else begin
          ovf <= 1'b1;
        end
      end else if (do_jump) begin
        pc <= target;
      end else begin
        pc <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack
// Directed self-checking bench for pc_stack. Each step drives one set of
// control inputs for exactly one rising edge, then samples the outputs 1ns
// after that edge and compares them with hand-computed values.
module tb_pc_stack;

  logic       clk;
  logic       reset;
  logic       stall;
  logic       jump;
  logic       call;
  logic       ret;
  logic [9:0] target;
  logic [9:0] pc;
  logic [3:0] sp;
  logic       empty;
  logic       full;
  logic       ovf;
  logic       unf;

  int checks;
  int errors;

  pc_stack #(
    .ADDR_W   (10),
    .DEPTH    (8),
    .RESET_PC (0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .stall  (stall),
    .jump   (jump),
    .call   (call),
    .ret    (ret),
    .target (target),
    .pc     (pc),
    .sp     (sp),
    .empty  (empty),
    .full   (full),
    .ovf    (ovf),
    .unf    (unf)
  );

  // Free-running 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of control inputs, let one rising edge sample them,
  // then settle 1ns past the edge before anything is checked.
  task automatic applyStimulus(input logic rs, input logic st, input logic jp,
                               input logic cl, input logic rt,
                               input logic [9:0] tgt);
    reset  = rs;
    stall  = st;
    jump   = jp;
    call   = cl;
    ret    = rt;
    target = tgt;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    stall  = 1'b0;
    jump   = 1'b0;
    call   = 1'b0;
    ret    = 1'b0;
    target = 10'h000;
  endtask

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
  endtask

  task automatic doJump(input logic [9:0] tgt);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, tgt);
  endtask

  task automatic doCall(input logic [9:0] tgt);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, tgt);
  endtask

  task automatic doRet();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    stall  = 1'b0;
    jump   = 1'b0;
    call   = 1'b0;
    ret    = 1'b0;
    target = 10'h000;

    // Reset state and five idle increments.
    doReset();
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_sp", sp, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_unf", unf, 0);
    for (int i = 1; i <= 5; i++) begin
      idle();
      checkOutput($sformatf("inc_pc%0d", i), pc, i);
      checkOutput($sformatf("inc_sp%0d", i), sp, 0);
      checkOutput($sformatf("inc_empty%0d", i), empty, 1);
    end
    checkOutput("inc_ovf", ovf, 0);
    checkOutput("inc_unf", unf, 0);

    // Wrap-around at the top of the address space.
    doJump(10'h3FE);
    checkOutput("jmp_pc", pc, 32'h3FE);
    idle();
    checkOutput("wrap_pc0", pc, 32'h3FF);
    idle();
    checkOutput("wrap_pc1", pc, 32'h000);
    idle();
    checkOutput("wrap_pc2", pc, 32'h001);

    // Simple call, two body instructions, return to call site + 1.
    doJump(10'h010);
    checkOutput("jmp10_pc", pc, 32'h010);
    doCall(10'h200);
    checkOutput("call_pc", pc, 32'h200);
    checkOutput("call_sp", sp, 1);
    checkOutput("call_empty", empty, 0);
    idle();
    checkOutput("body_pc0", pc, 32'h201);
    idle();
    checkOutput("body_pc1", pc, 32'h202);
    checkOutput("body_sp", sp, 1);
    doRet();
    checkOutput("ret_pc", pc, 32'h011);
    checkOutput("ret_sp", sp, 0);
    checkOutput("ret_empty", empty, 1);

    // Nine calls from reset: call i happens at pc 0x100+i-1 (or 0 for the
    // first) and pushes that +1, so the stack holds 0x001,0x101..0x107.
    doReset();
    for (int i = 0; i < 9; i++) begin
      doCall(10'h100 + 10'(i));
      checkOutput($sformatf("nest_pc%0d", i), pc, 32'h100 + i);
      checkOutput($sformatf("nest_sp%0d", i), sp, (i < 8) ? i + 1 : 8);
      checkOutput($sformatf("nest_full%0d", i), full, (i >= 7) ? 1 : 0);
      checkOutput($sformatf("nest_ovf%0d", i), ovf, (i == 8) ? 1 : 0);
    end
    for (int k = 0; k < 8; k++) begin
      doRet();
      checkOutput($sformatf("pop_pc%0d", k), pc, (k < 7) ? 32'h107 - k : 32'h001);
      checkOutput($sformatf("pop_sp%0d", k), sp, 7 - k);
    end
    checkOutput("pop_empty", empty, 1);
    checkOutput("pop_ovf_sticky", ovf, 1);
    checkOutput("pop_unf", unf, 0);

    // Underflow: ret on empty acts as increment and sets a sticky flag.
    doJump(10'h020);
    doRet();
    checkOutput("unf_pc", pc, 32'h021);
    checkOutput("unf_flag", unf, 1);
    checkOutput("unf_sp", sp, 0);
    idle();
    checkOutput("unf_sticky", unf, 1);
    checkOutput("unf_pc2", pc, 32'h022);
    doReset();
    checkOutput("unf_rst_flag", unf, 0);
    checkOutput("unf_rst_ovf", ovf, 0);
    checkOutput("unf_rst_pc", pc, 0);

    // Call at 0x3FF pushes the wrapped return address 0x000.
    doJump(10'h3FF);
    doCall(10'h010);
    checkOutput("wcall_pc", pc, 32'h010);
    doRet();
    checkOutput("wcall_ret_pc", pc, 32'h000);

    // Stall masks a call completely.
    doJump(10'h050);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h300);
    checkOutput("stall_pc", pc, 32'h050);
    checkOutput("stall_sp", sp, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
    checkOutput("stall_idle_pc", pc, 32'h050);
    idle();
    checkOutput("stall_resume_pc", pc, 32'h051);

    // Ret beats call: stack holds one entry 0x040.
    doJump(10'h03F);
    doCall(10'h060);
    checkOutput("pre_sp", sp, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h300);
    checkOutput("retcall_pc", pc, 32'h040);
    checkOutput("retcall_sp", sp, 0);

    // Ret on empty beats jump: increments and flags underflow.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h300);
    checkOutput("retjmp_pc", pc, 32'h041);
    checkOutput("retjmp_unf", unf, 1);

    // Call beats jump: stack grows.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h155);
    checkOutput("calljmp_pc", pc, 32'h155);
    checkOutput("calljmp_sp", sp, 1);

    // Reset beats jump and clears everything.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h123);
    checkOutput("rstjmp_pc", pc, 0);
    checkOutput("rstjmp_sp", sp, 0);
    checkOutput("rstjmp_unf", unf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
